// File: rtl/tl_param_buffer_if.sv
// TileLink-UL A/D channel bundle between one master and one slave port.
// A flows master -> slave, D flows slave -> master.
interface tl_param_buffer_if #(
  parameter int unsigned A_W = 80,
  parameter int unsigned D_W = 43
);
  logic           a_valid;
  logic           a_ready;
  logic [A_W-1:0] a_bits;
  logic           d_valid;
  logic           d_ready;
  logic [D_W-1:0] d_bits;

  modport master (
    output a_valid, a_bits, d_ready,
    input  a_ready, d_valid, d_bits
  );

  modport slave (
    input  a_valid, a_bits, d_ready,
    output a_ready, d_valid, d_bits
  );
endinterface

// File: rtl/tl_param_buffer.sv
// Parametrised TileLink-UL A/D buffer: one independent circular queue per
// channel, with optional flow-through and pipe modes; depth 0 is a wire.
module tl_param_buffer_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8,
  parameter bit          FLOW  = 1'b0,
  parameter bit          PIPE  = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_bits,
  output logic         deq_valid,
  input  logic         deq_ready,
  output logic [W-1:0] deq_bits,
  output logic [4:0]   count
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign deq_valid = enq_valid;
    assign enq_ready = deq_ready;
    assign deq_bits  = enq_bits;
    assign count     = '0;
  end else begin : g_fifo
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     ram [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [4:0]       count_q;
    logic             empty, full, enq_fire, deq_fire, bypass, do_enq, do_deq;

    always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == 5'(DEPTH));
      // Handshakes are held low throughout reset so no beat is lost or invented.
      enq_ready = reset && (!full || (PIPE && full && deq_ready));
      deq_valid = reset && (!empty || (FLOW && enq_valid));
      deq_bits  = (FLOW && empty) ? enq_bits : ram[head_q];
      enq_fire  = enq_valid && enq_ready;
      deq_fire  = deq_valid && deq_ready;
      bypass    = FLOW && empty && enq_fire && deq_fire;
      do_enq    = enq_fire && !bypass;
      do_deq    = deq_fire && !bypass;
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_enq) tail_q <= (tail_q == LAST) ? '0 : tail_q + 1'b1;
        if (do_deq) head_q <= (head_q == LAST) ? '0 : head_q + 1'b1;
        case ({do_enq, do_deq})
          2'b10:   count_q <= count_q + 5'd1;
          2'b01:   count_q <= count_q - 5'd1;
          default: count_q <= count_q;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (do_enq) ram[tail_q] <= enq_bits;
    end

    assign count = count_q;
  end
endmodule

module tl_param_buffer #(
  parameter int unsigned SRC_W   = 6,
  parameter int unsigned ADDR_W  = 29,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter bit          A_FLOW  = 1'b0,
  parameter bit          D_FLOW  = 1'b0,
  parameter bit          A_PIPE  = 1'b0,
  parameter bit          D_PIPE  = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  tl_param_buffer_if.slave  in_bus,
  tl_param_buffer_if.master out_bus,
  output logic [4:0]        a_count,
  output logic [4:0]        d_count
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned A_W    = 3 + 3 + 2 + SRC_W + ADDR_W + MASK_W + DATA_W + 1;
  localparam int unsigned D_W    = 3 + 2 + SRC_W + DATA_W;

  tl_param_buffer_queue #(
    .DEPTH (A_DEPTH),
    .W     (A_W),
    .FLOW  (A_FLOW),
    .PIPE  (A_PIPE)
  ) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (in_bus.a_valid),
    .enq_ready (in_bus.a_ready),
    .enq_bits  (in_bus.a_bits),
    .deq_valid (out_bus.a_valid),
    .deq_ready (out_bus.a_ready),
    .deq_bits  (out_bus.a_bits),
    .count     (a_count)
  );

  tl_param_buffer_queue #(
    .DEPTH (D_DEPTH),
    .W     (D_W),
    .FLOW  (D_FLOW),
    .PIPE  (D_PIPE)
  ) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (out_bus.d_valid),
    .enq_ready (out_bus.d_ready),
    .enq_bits  (out_bus.d_bits),
    .deq_valid (in_bus.d_valid),
    .deq_ready (in_bus.d_ready),
    .deq_bits  (in_bus.d_bits),
    .count     (d_count)
  );
endmodule

// File: doc/tl_param_buffer.md
# tl_param_buffer

Parametrised TileLink-UL buffer for the A (request) and D (response) channels. Each channel gets an independent FIFO of configurable depth with optional flow-through and pipe modes. Depth 0 degenerates to a pure wire. The block sits between a TileLink master port and slave port, for example ahead of the SPI control registers, to cut timing paths or absorb bursts without changing protocol semantics.

## Interface
- SRC_W, 6, source-ID width
- ADDR_W, 29, address width
- DATA_W, 32, data width (multiple of 8); MASK_W = DATA_W/8
- A_DEPTH, 2, A-channel entries (0..16); 0 = combinational pass-through
- D_DEPTH, 2, D-channel entries (0..16); 0 = combinational pass-through
- A_FLOW, 0, 1 = empty A queue forwards input in the same cycle
- D_FLOW, 0, as A_FLOW for D
- A_PIPE, 0, 1 = full A queue accepts when output dequeues same cycle
- D_PIPE, 0, as A_PIPE for D
- Derived widths:
  - A_W = 3+3+2+SRC_W+ADDR_W+MASK_W+DATA_W+1, packed MSB→LSB as {opcode, param, size, source, address, mask, data, corrupt}
  - D_W = 3+2+SRC_W+DATA_W, packed as {opcode, size, source, data}

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- in_a_valid  in  1  master request valid
- in_a_ready  out  1  buffer can accept A beat
- in_a_bits  in  A_W  packed A payload
- in_d_valid  out  1  response valid toward master
- in_d_ready  in  1  master accepts D beat
- in_d_bits  out  D_W  packed D payload
- out_a_valid  out  1  request valid toward slave
- out_a_ready  in  1  slave accepts A beat
- out_a_bits  out  A_W  packed A payload
- out_d_valid  in  1  slave response valid
- out_d_ready  out  1  buffer can accept D beat
- out_d_bits  in  D_W  packed D payload
- a_count  out  5  A entries held (0..A_DEPTH)
- d_count  out  5  D entries held (0..D_DEPTH)

## Operation
- Two identical, independent channel queues: A (in_a → out_a) and D (out_d → in_d). Generic description: enq side (valid/ready/bits) and deq side.
- DEPTH=0:
  - deq_valid = enq_valid, enq_ready = deq_ready, bits wired straight through.
  - count = 0; no state; FLOW/PIPE ignored.
- DEPTH>0 storage: circular RAM of DEPTH entries, head/tail pointers, count register.
  - Pointers wrap DEPTH-1 → 0; DEPTH need not be a power of 2.
  - empty = (count==0), full = (count==DEPTH).
- enq_ready = !full, or (PIPE && full && deq_ready).
- deq_valid = !empty, or (FLOW && enq_valid).
- deq_bits = RAM[head] when !empty; enq_bits when FLOW and empty.
- Transfer on a side occurs when valid && ready.
- FLOW bypass: empty, enq and deq both fire → beat passes combinationally, nothing written, count unchanged.
- Otherwise enq fire writes RAM[tail], tail++; deq fire reads head, head++.
- count' = count + enq_fire − deq_fire, bypass excluded; simultaneous enq+deq leaves count unchanged.
- Order preserved strictly; payload never modified, including corrupt and mask.
- No TileLink checking or source tracking; this is a pure buffer.

## Timing
- Reset (reset==0 at a rising edge):
  - head = tail = count = 0.
  - While reset is low, for DEPTH>0 channels, in_a_ready, out_d_ready, out_a_valid and in_d_valid are all forced 0.
  - a_count = d_count = 0.
  - Reset mid-operation discards all stored beats.
- First cycle after reset release: enq_ready=1, deq_valid=0, or enq_valid with FLOW.
- Latency, DEPTH>0 without FLOW: beat accepted at edge N is presented at deq from cycle N+1.
- Latency with FLOW and an empty queue: 0 cycles.
- Throughput:
  - DEPTH≥2: 1 beat/cycle sustained.
  - DEPTH=1 without PIPE: 1 beat per 2 cycles.
  - DEPTH=1 with PIPE: 1 beat/cycle.
- Output bits are stable while deq_valid && !deq_ready (head does not move).
- A and D share no state; A back-pressure never blocks D.

## Test plan
- Reset hold: reset=0 for 3 cycles with in_a_valid=1 → in_a_ready=0, out_a_valid=0, a_count=0. Release → in_a_ready=1 next cycle.
- Fill/drain, A_DEPTH=4, out_a_ready=0: push addresses 0x100..0x103 → a_count=4, in_a_ready=0. Then out_a_ready=1 → beats emerge in order 0x100..0x103, one per cycle, a_count decrements to 0.
- Wrap, A_DEPTH=3: stream 10 beats, source=0..9, with out_a_ready toggling 1,0,1,0… → all 10 delivered in order, no loss or duplicate.
- FLOW, D_DEPTH=2, D_FLOW=1, queue empty, out_d_valid=1, in_d_ready=1, data=0xDEADBEEF → in_d_valid=1 with 0xDEADBEEF in the same cycle, d_count stays 0.
- PIPE, A_DEPTH=1, A_PIPE=1: queue full, out_a_ready=1, in_a_valid=1 → in_a_ready=1. Sustained stream achieves 1 beat/cycle; a_count stays 1.
- DEPTH=0 on both channels: random valid/ready/bits → outputs equal inputs combinationally every cycle, counts 0.
